video_dither_6bit: RTL and testbench
====================================

Name: video_dither_6bit

Overview:
- Video output stage between the guest core's 8-bit-per-channel RGB/sync outputs and the board's 6-bit VGA DAC pins.
- Replaces plain truncation to bits [7:2] with 2x2 ordered dithering, optionally rotated per frame (temporal), so the two discarded LSBs still show up as average intensity.
- Delays HS, VS and DE by the same amount as the colour path, so all outputs stay aligned.

Parameters:
- TEMPORAL, 1, 1 = add the frame counter to the Bayer threshold; 0 = static spatial pattern only.

Ports:
- clk_sys  in  1  video/system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  pixel clock enable. All state advances only when ce_pix=1.
- enable  in  1  1 = dither; 0 = plain truncation.
- r_in  in  8  red from guest.
- g_in  in  8  green from guest.
- b_in  in  8  blue from guest.
- hs_in  in  1  horizontal sync, passed through with delay.
- vs_in  in  1  vertical sync, passed through with delay.
- de_in  in  1  active video. Tie to 1 if the source has no blanking signal.
- r_out  out  6  dithered red.
- g_out  out  6  dithered green.
- b_out  out  6  dithered blue.
- hs_out  out  1  delayed HS.
- vs_out  out  1  delayed VS.
- de_out  out  1  delayed DE.

Behaviour:
- Reset (async assert, sampled release): all outputs 0, every pipeline register 0, x_par=0, y_par=0, frame=0, previous-HS/VS/DE registers 0.
- No register changes on a clk_sys edge with ce_pix=0.
- Pipeline, two ce_pix-qualified stages; latency is exactly 2 ce_pix pulses for colour, HS, VS and DE alike.
- Stage 1 registers r/g/b/hs/vs/de_in, and also registers the threshold t computed from the current x_par, y_par and frame.
- Stage 2 registers the computed colour and the delayed syncs.
- Position tracking, all on ce_pix, using stage-1-registered signals:
  - x_par: cleared on a DE rising edge (prev 0, now 1); otherwise toggles on each ce_pix while DE=1.
  - y_par: toggles on each HS rising edge.
  - frame: 2-bit counter, increments on each VS rising edge and wraps from 3 to 0.
  - When the same ce_pix sees the DE rise and an HS/VS edge, each counter applies its own rule independently.
- Threshold:
  - Bayer index {y_par, x_par}: 00->0, 01->2, 10->3, 11->1.
  - t = (bayer + (TEMPORAL ? frame : 0)) mod 4, 2 bits wide.
- Per-channel arithmetic:
  - base = c[7:2].
  - inc = (c[1:0] > t).
  - out = base + inc, saturated to 63. 7-bit internal sum; if the sum exceeds 63, output 63.
- enable=0: out = c[7:2]. Syncs and DE still delayed by 2, and counters keep running.
- enable may change at any time; the new value applies to the pixel entering stage 2 on that ce_pix.
- DE=0 at stage 2: r/g/b_out forced to 0. hs_out/vs_out still follow their delayed inputs.
- Sync polarity is not interpreted for pass-through. Only the counters use rising edges; with active-low sync, the rising edge marks end of pulse, which is acceptable.
- Async reset mid-line: outputs drop to 0 immediately. The first line after release starts with y_par=0 and frame=0.

Test Plan:
- Reset, then 3 ce_pix with DE=1 and r_in=0x80 -> from cycle 2 on, r_out=0x20 every pixel regardless of position or frame; before that r_out=0.
- enable=1, TEMPORAL=0, r_in=0x82 over 2 lines of 4 pixels -> line0: 0x21,0x20,0x21,0x20; line1: 0x20,0x21,0x20,0x21. Average is 32.5.
- r_in=0xFF, all positions and frames -> r_out=63, never wraps to 0. r_in=0xFE -> 63 or 63, saturated.
- TEMPORAL=1, r_in=0x81, fixed pixel (0,0) over 4 frames -> t=0,1,2,3 gives r_out 0x21,0x20,0x20,0x20, then frame wraps to 0 and repeats.
- enable=0, r_in=0x83 -> r_out=0x20 at all positions. hs_out/vs_out/de_out equal the inputs delayed by exactly 2 ce_pix, with ce_pix=1 every 4th clk_sys.
- DE=0 with r_in=0xFF -> r_out=0 while hs_out toggles. Async reset mid-frame -> all outputs 0 within the same cycle, and the first active pixel after release uses t=0.

Source files
------------

// File: rtl/video_dither_6bit.sv
// video_dither_6bit
//   Output stage from the guest core's 8-bit RGB to 6-bit VGA DAC pins.
//   Two ce_pix-qualified pipeline stages apply 2x2 ordered (Bayer) dithering,
//   optionally rotated once per frame, so the two dropped LSBs survive as
//   average intensity. HS/VS/DE are delayed by the same two stages.
//
// Ports
//   clk_sys              video/system clock
//   reset                asynchronous, active-high reset
//   ce_pix               pixel clock enable; no state moves without it
//   enable               1 = dither, 0 = plain truncation to c[7:2]
//   r_in/g_in/b_in [7:0] colour from the guest
//   hs_in/vs_in/de_in    syncs and active-video flag from the guest
//   r_out/g_out/b_out    6-bit colour, forced to 0 outside active video
//   hs_out/vs_out/de_out syncs and DE delayed by 2 ce_pix pulses
//
// Parameters
//   TEMPORAL  1 = add the frame counter to the Bayer threshold

module video_dither_6bit #(
  parameter bit TEMPORAL = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       enable,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       de_in,
  output logic [5:0] r_out,
  output logic [5:0] g_out,
  output logic [5:0] b_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       de_out
);

  // stage 1
  logic [7:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [1:0] t1_q, t1_d;

  // position tracking
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic       x_par_q, x_par_d, y_par_q, y_par_d;
  logic [1:0] frame_q, frame_d;

  // stage 2
  logic [5:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;

  logic [1:0] bayer;
  logic [1:0] t_next;

  // The 7-bit sum only overflows 63 when base is already 63 and the
  // threshold asks for a bump; clamp rather than wrap to black.
  function automatic logic [5:0] dither_chan(input logic [7:0] c,
                                             input logic [1:0] t,
                                             input logic       en);
    logic [6:0] sum;
    sum = {1'b0, c[7:2]} + {6'd0, (en && (c[1:0] > t))};
    return (sum > 7'd63) ? 6'd63 : sum[5:0];
  endfunction

  always_comb begin
    case ({y_par_q, x_par_q})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    // 2-bit add wraps, giving the mod-4 rotation for free
    t_next = bayer + (TEMPORAL ? frame_q : 2'd0);
  end

  always_comb begin
    r1_d      = r1_q;
    g1_d      = g1_q;
    b1_d      = b1_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;
    de1_d     = de1_q;
    t1_d      = t1_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    de_prev_d = de_prev_q;
    x_par_d   = x_par_q;
    y_par_d   = y_par_q;
    frame_d   = frame_q;
    r2_d      = r2_q;
    g2_d      = g2_q;
    b2_d      = b2_q;
    hs2_d     = hs2_q;
    vs2_d     = vs2_q;
    de2_d     = de2_q;

    if (ce_pix) begin
      r1_d  = r_in;
      g1_d  = g_in;
      b1_d  = b_in;
      hs1_d = hs_in;
      vs1_d = vs_in;
      de1_d = de_in;
      t1_d  = t_next;

      // counters watch the stage-1 copies so edges are judged on
      // registered, glitch-free signals
      hs_prev_d = hs1_q;
      vs_prev_d = vs1_q;
      de_prev_d = de1_q;

      if (de1_q && !de_prev_q) begin
        x_par_d = 1'b0;
      end else if (de1_q) begin
        x_par_d = ~x_par_q;
      end

      if (hs1_q && !hs_prev_q) begin
        y_par_d = ~y_par_q;
      end

      if (vs1_q && !vs_prev_q) begin
        frame_d = frame_q + 2'd1;
      end

      hs2_d = hs1_q;
      vs2_d = vs1_q;
      de2_d = de1_q;
      r2_d  = de1_q ? dither_chan(r1_q, t1_q, enable) : 6'd0;
      g2_d  = de1_q ? dither_chan(g1_q, t1_q, enable) : 6'd0;
      b2_d  = de1_q ? dither_chan(b1_q, t1_q, enable) : 6'd0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r1_q      <= '0;
      g1_q      <= '0;
      b1_q      <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      de1_q     <= 1'b0;
      t1_q      <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      x_par_q   <= 1'b0;
      y_par_q   <= 1'b0;
      frame_q   <= '0;
      r2_q      <= '0;
      g2_q      <= '0;
      b2_q      <= '0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      de2_q     <= 1'b0;
    end else begin
      r1_q      <= r1_d;
      g1_q      <= g1_d;
      b1_q      <= b1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      de1_q     <= de1_d;
      t1_q      <= t1_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      x_par_q   <= x_par_d;
      y_par_q   <= y_par_d;
      frame_q   <= frame_d;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      de2_q     <= de2_d;
    end
  end

  assign r_out  = r2_q;
  assign g_out  = g2_q;
  assign b_out  = b2_q;
  assign hs_out = hs2_q;
  assign vs_out = vs2_q;
  assign de_out = de2_q;

endmodule

// File: tb/tb_video_dither_6bit.sv
module tb_video_dither_6bit;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ce_pix  = 1'b0;
  logic       enable  = 1'b1;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;

  logic [5:0] r_s, g_s, b_s, r_t, g_t, b_t;
  logic       hs_s, vs_s, de_s, hs_t, vs_t, de_t;

  video_dither_6bit #(.TEMPORAL(1'b0)) dut_s (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .enable(enable),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r_out(r_s), .g_out(g_s), .b_out(b_s),
    .hs_out(hs_s), .vs_out(vs_s), .de_out(de_s)
  );

  video_dither_6bit #(.TEMPORAL(1'b1)) dut_t (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .enable(enable),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r_out(r_t), .g_out(g_t), .b_out(b_t),
    .hs_out(hs_t), .vs_out(vs_t), .de_out(de_t)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pixel gets a threshold from the screen position known when it enters;
  // it is coloured with the enable value current one ce_pix later.
  typedef struct {
    int r, g, b;
    bit hs, vs, de;
    int ts, tt;
  } ent_t;

  ent_t m_s1;
  bit   m_pde, m_phs, m_pvs;
  int   mx, my, mf;
  int   e_r[2], e_g[2], e_b[2];
  bit   e_hs, e_vs, e_de;
  int   bayer_tab[4] = '{0, 2, 3, 1};

  function automatic int dith(input int c, input int t, input bit en);
    int v;
    v = c / 4;
    if (en && ((c % 4) > t)) v = v + 1;
    return (v > 63) ? 63 : v;
  endfunction

  task automatic model_reset();
    m_s1 = '{default: 0};
    m_pde = 0; m_phs = 0; m_pvs = 0;
    mx = 0; my = 0; mf = 0;
    for (int i = 0; i < 2; i++) begin
      e_r[i] = 0; e_g[i] = 0; e_b[i] = 0;
    end
    e_hs = 0; e_vs = 0; e_de = 0;
  endtask

  task automatic model_ce();
    int bay;
    e_hs = m_s1.hs;
    e_vs = m_s1.vs;
    e_de = m_s1.de;
    e_r[0] = m_s1.de ? dith(m_s1.r, m_s1.ts, enable) : 0;
    e_g[0] = m_s1.de ? dith(m_s1.g, m_s1.ts, enable) : 0;
    e_b[0] = m_s1.de ? dith(m_s1.b, m_s1.ts, enable) : 0;
    e_r[1] = m_s1.de ? dith(m_s1.r, m_s1.tt, enable) : 0;
    e_g[1] = m_s1.de ? dith(m_s1.g, m_s1.tt, enable) : 0;
    e_b[1] = m_s1.de ? dith(m_s1.b, m_s1.tt, enable) : 0;
    bay = bayer_tab[my * 2 + mx];
    if (m_s1.de && !m_pde) mx = 0;
    else if (m_s1.de)      mx = 1 - mx;
    if (m_s1.hs && !m_phs) my = 1 - my;
    if (m_s1.vs && !m_pvs) mf = (mf + 1) % 4;
    m_pde = m_s1.de; m_phs = m_s1.hs; m_pvs = m_s1.vs;
    m_s1.r  = int'(r_in);
    m_s1.g  = int'(g_in);
    m_s1.b  = int'(b_in);
    m_s1.hs = hs_in;
    m_s1.vs = vs_in;
    m_s1.de = de_in;
    m_s1.ts = bay;
    m_s1.tt = (bay + mf) % 4;
  endtask

  always @(negedge clk_sys) begin
    if (cmp_on) begin
      chk("r_out_static",   int'(r_s),  e_r[0]);
      chk("g_out_static",   int'(g_s),  e_g[0]);
      chk("b_out_static",   int'(b_s),  e_b[0]);
      chk("hs_out_static",  int'(hs_s), int'(e_hs));
      chk("vs_out_static",  int'(vs_s), int'(e_vs));
      chk("de_out_static",  int'(de_s), int'(e_de));
      chk("r_out_temporal", int'(r_t),  e_r[1]);
      chk("g_out_temporal", int'(g_t),  e_g[1]);
      chk("b_out_temporal", int'(b_t),  e_b[1]);
      chk("hs_out_temporal", int'(hs_t), int'(e_hs));
      chk("vs_out_temporal", int'(vs_t), int'(e_vs));
      chk("de_out_temporal", int'(de_t), int'(e_de));
    end
  end

  // ---------------- stimulus ----------------
  // Drive one pixel: wait 'gap' clocks with ce_pix low, then one ce_pix pulse.
  task automatic pix(input int r, input int g, input int b,
                     input bit hs, input bit vs, input bit de, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk_sys); #1;
    end
    r_in = 8'(r); g_in = 8'(g); b_in = 8'(b);
    hs_in = hs; vs_in = vs; de_in = de;
    ce_pix = 1'b1;
    @(posedge clk_sys); #1;
    model_ce();
    ce_pix = 1'b0;
  endtask

  // Blanking with a 2-pixel HS pulse (and optional VS), then an active run.
  task automatic line(input int npix, input int r, input int g,
                      input bit vs_pulse, input int gap);
    for (int i = 0; i < 4; i++) pix(0, 0, 0, (i < 2), vs_pulse, 1'b0, gap);
    for (int i = 0; i < npix; i++) pix(r, (g < 0) ? int'($urandom_range(0, 255)) : g,
                                       int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, gap);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("reset_r_out", int'(r_s) + int'(r_t), 0);
    chk("reset_syncs", int'({hs_s, vs_s, de_s, hs_t, vs_t, de_t}), 0);
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk_sys); #1;
    cmp_on = 1'b1;
    @(posedge clk_sys); #1;
    chk("reset_r_out", int'(r_s), 0);
    reset = 1'b0;

    // 0x80 has no fractional part: 0x20 wherever it lands, 0 until 2 pulses
    pix(8'h80, 8'h40, 8'hC0, 0, 0, 1, 0);
    chk("lat_before_2", int'(r_s), 0);
    pix(8'h80, 8'h40, 8'hC0, 0, 0, 1, 0);
    chk("lat_at_2_s", int'(r_s), 8'h20);
    chk("lat_at_2_t", int'(r_t), 8'h20);
    pix(8'h80, 8'h40, 8'hC0, 0, 0, 1, 0);
    chk("lat_at_3_g", int'(g_s), 8'h10);
    chk("lat_at_3_b", int'(b_t), 8'h30);

    // 0x82: half-step intensity over lines and frames
    line(4, 8'h82, -1, 1, 0);
    for (int l = 0; l < 4; l++) line(4, 8'h82, -1, 0, 0);

    // saturation: 0xFF / 0xFE must clamp to 63
    for (int f = 0; f < 5; f++) begin
      line(3, 8'hFF, 8'hFE, 1, 0);
      line(5, 8'hFF, 8'hFE, 0, 0);
    end
    pix(8'hFF, 8'hFE, 8'hFF, 0, 0, 1, 0);
    chk("sat_ff_s", int'(r_s), 63);
    chk("sat_ff_t", int'(r_t), 63);
    chk("sat_fe_t", int'(g_t), 63);

    // temporal rotation with 0x81
    for (int f = 0; f < 6; f++) begin
      line(4, 8'h81, -1, 1, 0);
      line(4, 8'h81, -1, 0, 0);
    end

    // truncation, ce_pix every 4th clock
    enable = 1'b0;
    for (int l = 0; l < 3; l++) line(4, 8'h83, -1, (l == 0), 3);
    pix(8'h83, 8'h83, 8'h83, 0, 0, 1, 3);
    chk("trunc_83", int'(r_s), 8'h20);
    chk("trunc_83_t", int'(r_t), 8'h20);
    enable = 1'b1;

    // blanking with full white and toggling HS
    for (int i = 0; i < 12; i++) pix(8'hFF, 8'hFF, 8'hFF, i[1], 0, 0, 0);
    chk("blank_r_zero", int'(r_s) + int'(r_t), 0);

    // random traffic including enable changes and irregular ce_pix
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      pix(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 3)));
    end
    enable = 1'b1;

    // mid-line reset: outputs drop before any clock edge
    line(2, 8'h82, -1, 0, 0);
    do_reset();

    // first active pixel after release sees t=0: 0x82 -> 0x21 on both
    pix(8'h82, 8'h82, 8'h82, 0, 0, 1, 0);
    pix(0, 0, 0, 0, 1, 0, 0);
    chk("post_reset_t0_s", int'(r_s), 8'h21);
    chk("post_reset_t0_t", int'(r_t), 8'h21);
    // VS rise bumps frame to 1; next pixel at (0,0): static t=0, temporal t=1
    pix(0, 0, 0, 0, 0, 0, 0);
    pix(8'h81, 8'h81, 8'h81, 0, 0, 1, 0);
    pix(0, 0, 0, 0, 0, 0, 0);
    chk("frame1_081_s", int'(r_s), 8'h21);
    chk("frame1_081_t", int'(r_t), 8'h20);

    repeat (3) pix(0, 0, 0, 0, 0, 0, 1);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
